// File: rtl/jk_pkg.sv
// jk_pkg: shared JK operation and sequencer state encodings
package jk_pkg;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COMMIT} state_t;
endpackage

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: master-slave JK flip-flop bank with separate master and slave enables
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             m_en,
  input  logic             s_en,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_m, r_q, w_m;
  always_comb begin
    w_m = r_q;
    for (int i = 0; i < WIDTH; i++)
      w_m[i] = {j[i], k[i]} == JK_TGL ? ~r_q[i] : {j[i], k[i]} == JK_SET ? 1'b1 :
               {j[i], k[i]} == JK_RST ? 1'b0 : r_q[i];
  end
  // Master samples every bit so untargeted bits carry their current value into the slave.
  always_ff @(posedge clk) begin
    r_m <= clr ? '0 : m_en ? w_m : r_m;
    r_q <= clr ? '0 : s_en ? r_m : r_q;
  end
  assign q = r_q;
endmodule

// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin access to a shared JK bank through an APPLY/COMMIT sequencer
module jk_bank_scheduler
  import jk_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [NREQ*IDXW-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic                 busy,
  output logic [WIDTH-1:0]     q
);
  localparam int SELW = $clog2(NREQ);
  state_t           r_state, w_next;
  logic [SELW-1:0]  r_ptr, r_sel, w_off, w_pick;
  logic [SELW:0]    w_sum;
  logic [NREQ-1:0]  w_rot;
  logic [1:0]       r_op, w_op;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic [WIDTH-1:0] w_dec, w_j, w_k;
  // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_rot = NREQ'({req, req} >> r_ptr);
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (w_rot[i]) w_off = SELW'(i);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick = w_sum >= (SELW+1)'(NREQ) ? SELW'(w_sum - (SELW+1)'(NREQ)) : w_sum[SELW-1:0];
    w_op = 2'(op >> (2 * int'(w_pick)));
    w_idx = IDXW'(idx >> (IDXW * int'(w_pick)));
  end
  always_ff @(posedge clk) r_state <= clr ? S_IDLE : w_next;
  always_comb
    w_next = r_state == S_IDLE ? (|req ? S_APPLY : S_IDLE) :
             r_state == S_APPLY ? S_COMMIT : S_IDLE;
  always_comb begin
    busy = r_state != S_IDLE;
    gnt = busy ? NREQ'(1) << r_sel : '0;
    ack = r_state == S_COMMIT ? gnt : '0;
    err = r_state == S_COMMIT && w_dec == '0;
  end
  always_ff @(posedge clk)
    if (clr) begin
      r_ptr <= '0;
      r_sel <= '0;
      r_op <= JK_HOLD;
      r_idx <= '0;
    end else if (r_state == S_IDLE && |req) begin
      r_sel <= w_pick;
      r_op <= w_op;
      r_idx <= w_idx;
    end else if (r_state == S_COMMIT)
      r_ptr <= r_sel == SELW'(NREQ - 1) ? '0 : r_sel + SELW'(1);
  // An out-of-range index shifts the one-hot out entirely, so no bit is driven.
  assign w_dec = WIDTH'(1) << r_idx;
  assign w_j = r_state == S_APPLY && r_op[1] ? w_dec : '0;
  assign w_k = r_state == S_APPLY && r_op[0] ? w_dec : '0;
  jk_reg_bank #(.WIDTH(WIDTH)) u_bank (
    .clk (clk),
    .clr (clr),
    .j   (w_j),
    .k   (w_k),
    .m_en(r_state == S_APPLY),
    .s_en(r_state == S_COMMIT),
    .q   (q)
  );
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// tb_jk_bank_scheduler: directed and random stimulus against a transaction-level model, WIDTH 8 and 6
module tb_jk_bank_scheduler;
  localparam int NREQ = 4;
  localparam int IDXW = 3;
  logic clk = 0;
  logic clr;
  logic [NREQ-1:0] req;
  logic [2*NREQ-1:0] op;
  logic [NREQ*IDXW-1:0] idx;
  logic [NREQ-1:0] gnt8, ack8, gnt6, ack6;
  logic err8, busy8, err6, busy6;
  logic [7:0] q8;
  logic [5:0] q6;
  int n_chk = 0, n_fail = 0;
  int m_age, m_sel, m_ptr, m_op, m_idx;
  logic [7:0] m_q8, m_q6;

  always #5 clk = ~clk;

  jk_bank_scheduler #(.NREQ(NREQ), .WIDTH(8)) u8 (
    .clk(clk), .clr(clr), .req(req), .op(op), .idx(idx),
    .gnt(gnt8), .ack(ack8), .err(err8), .busy(busy8), .q(q8)
  );
  jk_bank_scheduler #(.NREQ(NREQ), .WIDTH(6)) u6 (
    .clk(clk), .clr(clr), .req(req), .op(op), .idx(idx),
    .gnt(gnt6), .ack(ack6), .err(err6), .busy(busy6), .q(q6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] jk_apply(input logic [7:0] v, input int o, input int i, input int w);
    logic [7:0] r = v;
    if (i < w) begin
      if (o == 1) r[i] = 1'b0;
      else if (o == 2) r[i] = 1'b1;
      else if (o == 3) r[i] = ~r[i];
    end
    return r;
  endfunction

  // Command-level model: age counts cycles since a command was accepted (0 = idle).
  task automatic model_step();
    bit found = 0;
    if (clr) begin
      m_age = 0; m_ptr = 0; m_sel = 0; m_q8 = 0; m_q6 = 0;
    end else if (m_age == 0) begin
      for (int n = 0; n < NREQ; n++)
        if (!found && req[(m_ptr + n) % NREQ]) begin
          found = 1;
          m_sel = (m_ptr + n) % NREQ;
        end
      if (found) begin
        m_op = int'((op >> (2 * m_sel)) & 8'h3);
        m_idx = int'((idx >> (IDXW * m_sel)) & 12'h7);
        m_age = 1;
      end
    end else if (m_age == 1) m_age = 2;
    else begin
      m_q8 = jk_apply(m_q8, m_op, m_idx, 8);
      m_q6 = jk_apply(m_q6, m_op, m_idx, 6);
      m_ptr = (m_sel + 1) % NREQ;
      m_age = 0;
    end
  endtask

  task automatic check_outs();
    logic [NREQ-1:0] eg = m_age != 0 ? NREQ'(1 << m_sel) : '0;
    logic [NREQ-1:0] ea = m_age == 2 ? eg : '0;
    chk("gnt8", gnt8, eg);
    chk("gnt6", gnt6, eg);
    chk("ack8", ack8, ea);
    chk("ack6", ack6, ea);
    chk("busy8", busy8, m_age != 0);
    chk("busy6", busy6, m_age != 0);
    chk("err8", err8, 0);
    chk("err6", err6, m_age == 2 && m_idx >= 6);
    chk("q8", q8, m_q8);
    chk("q6", q6, m_q6[5:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic set_cmd(input int r, input logic on, input logic [1:0] o, input logic [2:0] i);
    req[r] = on;
    op[2*r +: 2] = o;
    idx[IDXW*r +: IDXW] = i;
  endtask

  task automatic do_clr();
    clr = 1; req = '0;
    tick();
    clr = 0;
  endtask

  initial begin
    int last, nack;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    clr = 1; req = '0; op = '0; idx = '0;
    m_age = 0; m_ptr = 0; m_sel = 0; m_op = 0; m_idx = 0; m_q8 = 0; m_q6 = 0;
    // reset, then idle
    tick(); tick();
    clr = 0;
    for (int t = 0; t < 3; t++) tick();
    chk("idle_q", q8, 8'h00);
    chk("idle_busy", busy8, 0);
    chk("idle_gnt", gnt8, 0);
    // set bit 3 then toggle it back
    set_cmd(0, 1, 2'b10, 3'd3);
    tick();
    chk("set_gnt_t1", gnt8, 4'b0001);
    chk("set_ack_t1", ack8, 4'b0000);
    tick();
    chk("set_ack_t2", ack8, 4'b0001);
    req = '0;
    tick();
    chk("set_q_t3", q8, 8'h08);
    set_cmd(0, 1, 2'b11, 3'd3);
    tick(); tick();
    req = '0;
    tick();
    chk("tgl_q", q8, 8'h00);
    // all requesters held: round-robin order and spacing
    do_clr();
    for (int r = 0; r < NREQ; r++) set_cmd(r, 1, 2'b10, 3'(r));
    last = 0; nack = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (ack8 != 0) begin
        if (nack < 5) chk("rr_order", $clog2(ack8), exp_order[nack]);
        if (nack > 0) chk("rr_gap", t - last, 3);
        last = t; nack++;
      end
    end
    chk("rr_count", nack, 5);
    chk("rr_q", q8, 8'h0f);
    // out-of-range index on the 6-bit bank
    do_clr();
    set_cmd(2, 1, 2'b10, 3'd7);
    tick(); tick();
    chk("oor_ack6", ack6, 4'b0100);
    chk("oor_err6", err6, 1);
    req = '0;
    tick();
    chk("oor_q6", q6, 6'h00);
    chk("oor_q8", q8, 8'h80);
    // reset during APPLY aborts and rewinds the pointer
    do_clr();
    set_cmd(1, 1, 2'b10, 3'd0);
    tick(); tick();
    req = '0;
    tick();
    set_cmd(2, 1, 2'b10, 3'd5);
    tick();
    chk("abort_gnt", gnt8, 4'b0100);
    clr = 1;
    tick();
    clr = 0;
    chk("abort_ack", ack8, 0);
    chk("abort_q", q8, 8'h00);
    req = 4'b1111;
    tick();
    chk("abort_next", gnt8, 4'b0001);
    // requester drops during APPLY, command still completes
    do_clr();
    set_cmd(0, 1, 2'b10, 3'd0);
    tick(); tick();
    req = '0;
    tick();
    set_cmd(1, 1, 2'b01, 3'd0);
    tick();
    req[1] = 0;
    tick();
    chk("drop_ack", ack8, 4'b0010);
    tick();
    chk("drop_q0", q8[0], 0);
    // random traffic
    do_clr();
    for (int c = 0; c < 3000; c++) begin
      clr = $urandom_range(0, 49) == 0;
      for (int r = 0; r < NREQ; r++) begin
        if (m_age == 2 && m_sel == r) begin
          if ($urandom_range(0, 3) != 0) req[r] = 0;
          else set_cmd(r, 1, 2'($urandom), 3'($urandom));
        end else if (m_age == 1 && m_sel == r) begin
          if ($urandom_range(0, 7) == 0) req[r] = 0;
          op[2*r +: 2] = 2'($urandom);
          idx[IDXW*r +: IDXW] = 3'($urandom);
        end else if (!req[r] && $urandom_range(0, 2) == 0)
          set_cmd(r, 1, 2'($urandom), 3'($urandom));
      end
      tick();
    end
    clr = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
